keypad_entry: RTL

KEYPAD_ENTRY -- requirements
Module: keypad_entry

---
 rtl/keypad_entry.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - 4x4 matrix keypad scanner with debounce and digit shift register
//
// Drives one active-low column at a time, watches the active-low rows, and
// confirms a key only after DEBOUNCE_SCANS consecutive agreeing samples taken
// once per column period. Confirmed keys are shifted into a 32-bit digit
// register, newest digit in the low nibble.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   clr       in   synchronous clear of data
//   row[3:0]  in   keypad rows, active-low
//   col[3:0]  out  keypad column drive, active-low, one-hot-low
//   key_code  out  hex code (row*4+col) of the last confirmed key
//   key_valid out  one-cycle pulse per confirmed press
//   data      out  entered digits, one nibble each
module keypad_entry #(
  parameter int SCAN_TICKS     = 100_000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [31:0] data
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     row_meta_q, rs_q;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [3:0]     col_q, col_d;
  logic [1:0]     r_q, r_d, c_q, c_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     key_code_q, key_code_d;
  logic           key_valid_q, key_valid_d;
  logic [31:0]    data_q, data_d;

  logic           tick;
  logic           confirm;
  logic [1:0]     scan_r, scan_c;
  logic [3:0]     new_code;

  assign tick = (tick_cnt_q == TICK_LAST);

  // Lowest-index low row wins when several keys share the active column.
  always_comb begin
    scan_r = 2'd3;
    if (!rs_q[0])      scan_r = 2'd0;
    else if (!rs_q[1]) scan_r = 2'd1;
    else if (!rs_q[2]) scan_r = 2'd2;
  end

  always_comb begin
    scan_c = 2'd3;
    if (!col_q[0])      scan_c = 2'd0;
    else if (!col_q[1]) scan_c = 2'd1;
    else if (!col_q[2]) scan_c = 2'd2;
  end

  // State register: every flop in the block lives here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q  <= 4'b1111;
      rs_q        <= 4'b1111;
      tick_cnt_q  <= '0;
      state_q     <= S_SCAN;
      col_q       <= 4'b1110;
      r_q         <= 2'd0;
      c_q         <= 2'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      data_q      <= 32'd0;
    end else begin
      row_meta_q  <= row;
      rs_q        <= row_meta_q;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      col_q       <= col_d;
      r_q         <= r_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      data_q      <= data_d;
    end
  end

  // Next-state logic; the FSM only moves on tick cycles.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    state_d    = state_q;
    col_d      = col_q;
    r_d        = r_q;
    c_d        = c_q;
    cnt_d      = cnt_q;
    confirm    = 1'b0;
    if (tick) begin
      case (state_q)
        S_SCAN: begin
          if (&rs_q) begin
            col_d = {col_q[2:0], col_q[3]};
          end else begin
            r_d = scan_r;
            c_d = scan_c;
            if (DEBOUNCE_SCANS <= 1) begin
              state_d = S_HELD;
              cnt_d   = '0;
              confirm = 1'b1;
            end else begin
              state_d = S_DEBOUNCE;
              cnt_d   = CW'(1);
            end
          end
        end
        S_DEBOUNCE: begin
          if (!rs_q[r_q]) begin
            if (cnt_q + CW'(1) == CNT_LAST) begin
              state_d = S_HELD;
              cnt_d   = '0;
              confirm = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = S_SCAN;
            cnt_d   = '0;
          end
        end
        S_HELD: begin
          if (rs_q[r_q]) begin
            if (DEBOUNCE_SCANS <= 1) begin
              state_d = S_SCAN;
              cnt_d   = '0;
            end else begin
              state_d = S_RELEASE;
              cnt_d   = CW'(1);
            end
          end
        end
        default: begin
          if (rs_q[r_q]) begin
            if (cnt_q + CW'(1) == CNT_LAST) begin
              state_d = S_SCAN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = S_HELD;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // Output logic; clr beats a same-edge shift but not the code/pulse update.
  always_comb begin
    new_code    = {r_d, c_d};
    key_valid_d = confirm;
    key_code_d  = confirm ? new_code : key_code_q;
    data_d      = data_q;
    if (confirm) data_d = {data_q[27:0], new_code};
    if (clr)     data_d = 32'd0;
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign data      = data_q;

endmodule
